// File: rtl/knn_ctrl_if.sv
// Bus between knn_ctrl and the KNN distance/insertion core.
// The controller drives the training stream; the core returns its neighbour labels.
interface knn_ctrl_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LABEL       = 8,
  parameter int unsigned N_NEIGHBOUR = 10
);
  logic                         core_clr;
  logic                         core_valid;
  logic [DATA_W-1:0]            core_test;
  logic [DATA_W-1:0]            core_point;
  logic [LABEL-1:0]             core_label;
  logic [N_NEIGHBOUR*LABEL-1:0] core_info;

  modport master (
    output core_clr, core_valid, core_test, core_point, core_label,
    input  core_info
  );

  modport slave (
    input  core_clr, core_valid, core_test, core_point, core_label,
    output core_info
  );
endinterface

// File: rtl/knn_ctrl.sv
// KNN sequencer: streams stored training points into the core, then majority-votes the K labels.
// Optional KNN_CTRL_PERF_EN adds a 32-bit busy-cycle counter on perf_cycles.
module knn_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LABEL       = 8,
  parameter int unsigned N_NEIGHBOUR = 10,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned CORE_LAT    = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ld_en,
  input  logic [$clog2(DEPTH)-1:0]         ld_addr,
  input  logic [DATA_W-1:0]                ld_point,
  input  logic [LABEL-1:0]                 ld_label,
  output logic                             ld_err,
  input  logic [$clog2(DEPTH):0]           n_points,
  input  logic [DATA_W-1:0]                test_point,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [LABEL-1:0]                 class_out,
  output logic [$clog2(N_NEIGHBOUR):0]     class_votes,
`ifdef KNN_CTRL_PERF_EN
  output logic [31:0]                      perf_cycles,
`endif
  knn_ctrl_if.master                       core
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned VW = $clog2(N_NEIGHBOUR) + 1;
  localparam int unsigned KW = (N_NEIGHBOUR > 1) ? $clog2(N_NEIGHBOUR) : 1;
  localparam int unsigned LW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_VOTE   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [DATA_W-1:0] mem_point [DEPTH];
  logic [LABEL-1:0]  mem_label [DEPTH];

  logic [2:0]        state,    state_nx;
  logic [NW-1:0]     n_eff,    n_eff_nx;
  logic [NW-1:0]     idx,      idx_nx;
  logic [LW-1:0]     lat,      lat_nx;
  logic [KW-1:0]     j,        j_nx;
  logic [KW-1:0]     m,        m_nx;
  logic [VW-1:0]     cnt,      cnt_nx;
  logic [VW-1:0]     best_cnt, best_cnt_nx;
  logic [LABEL-1:0]  best_lbl, best_lbl_nx;
  logic [DATA_W-1:0] test_nx;
  logic              accept;
  logic [VW-1:0]     kv;
  logic [VW-1:0]     cnt_hit;
  logic [LABEL-1:0]  slot [N_NEIGHBOUR];

  // Unpack the neighbour list; slot 0 is the nearest.
  always_comb begin
    for (int s = 0; s < int'(N_NEIGHBOUR); s++) begin
      slot[s] = core.core_info[s*LABEL +: LABEL];
    end
  end

  // Training memory is only writable while idle.
  always_ff @(posedge clk) begin
    if (ld_en && !busy) begin
      mem_point[ld_addr] <= ld_point;
      mem_label[ld_addr] <= ld_label;
    end
  end

  // Number of slots taking part in the vote.
  always_comb begin
    if (32'(n_eff) > N_NEIGHBOUR) kv = VW'(N_NEIGHBOUR);
    else                          kv = VW'(n_eff);
  end

  // Next-state and datapath next values.
  always_comb begin
    state_nx    = state;
    n_eff_nx    = n_eff;
    idx_nx      = idx;
    lat_nx      = lat;
    j_nx        = j;
    m_nx        = m;
    cnt_nx      = cnt;
    best_cnt_nx = best_cnt;
    best_lbl_nx = best_lbl;
    test_nx     = core.core_test;
    accept      = 1'b0;
    cnt_hit     = cnt + VW'(slot[m] == slot[j]);

    case (state)
      S_IDLE: begin
        if (start) begin
          accept      = 1'b1;
          state_nx    = S_CLEAR;
          test_nx     = test_point;
          n_eff_nx    = (32'(n_points) > DEPTH) ? NW'(DEPTH) : n_points;
          idx_nx      = '0;
          lat_nx      = '0;
          j_nx        = '0;
          m_nx        = '0;
          cnt_nx      = '0;
          best_cnt_nx = '0;
          best_lbl_nx = '0;
        end
      end
      S_CLEAR: begin
        state_nx = (n_eff == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (idx == n_eff) state_nx = (CORE_LAT == 0) ? S_VOTE : S_DRAIN;
      end
      S_DRAIN: begin
        if (lat == LW'(CORE_LAT - 1)) state_nx = S_VOTE;
        else                          lat_nx   = lat + LW'(1);
      end
      S_VOTE: begin
        if (VW'(m) == kv - VW'(1)) begin
          // Strict compare keeps the earliest (nearest) candidate on ties.
          if (cnt_hit > best_cnt) begin
            best_cnt_nx = cnt_hit;
            best_lbl_nx = slot[j];
          end
          cnt_nx = '0;
          m_nx   = '0;
          if (VW'(j) == kv - VW'(1)) begin
            state_nx = S_DONE;
            j_nx     = '0;
          end else begin
            j_nx = j + KW'(1);
          end
        end else begin
          m_nx   = m + KW'(1);
          cnt_nx = cnt_hit;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // Memory read address advances with every streamed entry.
    if (state_nx == S_STREAM) idx_nx = idx + NW'(1);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      n_eff            <= '0;
      idx              <= '0;
      lat              <= '0;
      j                <= '0;
      m                <= '0;
      cnt              <= '0;
      best_cnt         <= '0;
      best_lbl         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      ld_err           <= 1'b0;
      class_out        <= '0;
      class_votes      <= '0;
      core.core_clr    <= 1'b0;
      core.core_valid  <= 1'b0;
      core.core_test   <= '0;
      core.core_point  <= '0;
      core.core_label  <= '0;
    end else begin
      state            <= state_nx;
      n_eff            <= n_eff_nx;
      idx              <= idx_nx;
      lat              <= lat_nx;
      j                <= j_nx;
      m                <= m_nx;
      cnt              <= cnt_nx;
      best_cnt         <= best_cnt_nx;
      best_lbl         <= best_lbl_nx;
      busy             <= (state_nx != S_IDLE);
      done             <= (state_nx == S_DONE);
      ld_err           <= ld_en && busy;
      core.core_clr    <= (state_nx == S_CLEAR);
      core.core_valid  <= (state_nx == S_STREAM);
      core.core_test   <= test_nx;
      if (state_nx == S_STREAM) begin
        core.core_point <= mem_point[idx[AW-1:0]];
        core.core_label <= mem_label[idx[AW-1:0]];
      end
      if (accept) begin
        class_out   <= '0;
        class_votes <= '0;
      end else if (state_nx == S_DONE) begin
        class_out   <= best_lbl_nx;
        class_votes <= best_cnt_nx;
      end
    end
  end

`ifdef KNN_CTRL_PERF_EN
  // Run-time counter: restarts on each accepted start, freezes once idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         perf_cycles <= '0;
    else if (accept) perf_cycles <= '0;
    else if (busy)   perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_knn_ctrl.sv
// Scoreboard bench for knn_ctrl: stimulus pushes expected stream entries and results,
// a negedge monitor pops and compares them when the DUT presents core_valid or done.
module tb_knn_ctrl;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LABEL    = 8;
  localparam int unsigned K        = 3;
  localparam int unsigned DEPTH    = 64;
  localparam int unsigned CORE_LAT = 3;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned VW       = $clog2(K) + 1;

  typedef struct packed {
    logic [LABEL-1:0]  cls;
    logic [VW-1:0]     votes;
    logic [31:0]       cyc;
    logic [DATA_W-1:0] tp;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_en;
  logic [AW-1:0]     ld_addr;
  logic [DATA_W-1:0] ld_point;
  logic [LABEL-1:0]  ld_label;
  logic              ld_err;
  logic [AW:0]       n_points;
  logic [DATA_W-1:0] test_point;
  logic              start;
  logic              busy;
  logic              done;
  logic [LABEL-1:0]  class_out;
  logic [VW-1:0]     class_votes;
  logic [K*LABEL-1:0] info_r;
`ifdef KNN_CTRL_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  knn_ctrl_if #(.DATA_W(DATA_W), .LABEL(LABEL), .N_NEIGHBOUR(K)) core_bus ();
  assign core_bus.core_info = info_r;

  knn_ctrl #(
    .DATA_W(DATA_W), .LABEL(LABEL), .N_NEIGHBOUR(K), .DEPTH(DEPTH), .CORE_LAT(CORE_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_point    (ld_point),
    .ld_label    (ld_label),
    .ld_err      (ld_err),
    .n_points    (n_points),
    .test_point  (test_point),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .class_out   (class_out),
    .class_votes (class_votes),
`ifdef KNN_CTRL_PERF_EN
    .perf_cycles (perf_cycles),
`endif
    .core        (core_bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic [31:0] cyc = '0;
  exp_t exp_q[$];
  logic [DATA_W+LABEL-1:0] str_q[$];
  logic [DATA_W-1:0] m_pt [DEPTH];
  logic [LABEL-1:0]  m_lb [DEPTH];

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every streamed entry and every completion against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (core_bus.core_valid) begin
        if (str_q.size() == 0) check("unexpected core_valid", 64'd1, 64'd0);
        else check("stream entry", 64'({core_bus.core_point, core_bus.core_label}), 64'(str_q.pop_front()));
      end
      if (done) begin
        if (exp_q.size() == 0) check("unexpected done", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("class_out", 64'(class_out), 64'(e.cls));
          check("class_votes", 64'(class_votes), 64'(e.votes));
          check("done cycle", 64'(cyc), 64'(e.cyc));
          check("core_test", 64'(core_bus.core_test), 64'(e.tp));
        end
      end
    end
  end

  task automatic load(input int i, input logic [DATA_W-1:0] pt, input logic [LABEL-1:0] lb);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = AW'(i); ld_point = pt; ld_label = lb;
    m_pt[i] = pt; m_lb[i] = lb;
    @(negedge clk);
    ld_en = 1'b0;
    if (i == 0) check("ld_err idle", 64'(ld_err), 64'd0);
  endtask

  // Issue a start with hand-computed class, votes and latency; returns in the CLEAR cycle.
  task automatic start_run(input int n, input logic [K*LABEL-1:0] info,
                           input logic [LABEL-1:0] cls, input logic [VW-1:0] votes,
                           input int lat, input logic [DATA_W-1:0] tp);
    exp_t e;
    @(negedge clk);
    info_r = info; n_points = (AW+1)'(n); test_point = tp; start = 1'b1;
    e.cls = cls; e.votes = votes; e.cyc = cyc + 32'(lat); e.tp = tp;
    exp_q.push_back(e);
    for (int i = 0; i < n && i < int'(DEPTH); i++) str_q.push_back({m_pt[i], m_lb[i]});
    @(negedge clk);
    start = 1'b0;
    check("core_clr after start", 64'({core_bus.core_clr, busy}), 64'd3);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    check("run completed", 64'(exp_q.size()), 64'd0);
    check("stream fully consumed", 64'(str_q.size()), 64'd0);
    exp_q.delete();
    str_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_point = '0; ld_label = '0;
    n_points = 7'd4; test_point = 32'hDEAD_BEEF; info_r = '0;

    // Reset with start held high.
    repeat (3) @(negedge clk);
    check("reset busy/done/ld_err/clr/valid", 64'({busy, done, ld_err, core_bus.core_clr, core_bus.core_valid}), 64'd0);
    check("reset class", 64'({class_out, class_votes}), 64'd0);
    check("reset core bus", 64'({core_bus.core_test, core_bus.core_point, core_bus.core_label}), 64'd0);
    start = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [LABEL-1:0] lb;
      case (i)
        0: lb = 8'd2;
        1: lb = 8'd2;
        2: lb = 8'd5;
        3: lb = 8'd7;
        default: lb = 8'(i + 20);
      endcase
      load(i, {16'(i), 16'(i * 3 + 100)}, lb);
    end

    // Basic run: info slot0..2 = 2,5,2.
    start_run(4, {8'd2, 8'd5, 8'd2}, 8'd2, 3'd2, 18, 32'h0011_0022);
    wait_done();
`ifdef KNN_CTRL_PERF_EN
    @(negedge clk);
    check("perf_cycles", 64'(perf_cycles), 64'd18);
`endif

    // Tie run: 7,5,3 -> nearest wins; also load and restart while streaming.
    start_run(4, {8'd3, 8'd5, 8'd7}, 8'd7, 3'd1, 18, 32'h0033_0044);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 6'd1; ld_point = 32'hBAD0_BAD0; ld_label = 8'hEE; start = 1'b1;
    @(negedge clk);
    ld_en = 1'b0; start = 1'b0;
    check("ld_err busy", 64'(ld_err), 64'd1);
    wait_done();

    // Back-to-back: start in the IDLE cycle after done; memory must be unchanged.
    start_run(4, {8'd2, 8'd5, 8'd2}, 8'd2, 3'd2, 18, 32'h0055_0066);
    wait_done();

    // Empty run.
    start_run(0, {8'd2, 8'd5, 8'd2}, 8'd0, 3'd0, 2, 32'h0077_0088);
    wait_done();

    // Two points: only slots 0,1 (5,7) vote.
    start_run(2, {8'd7, 8'd7, 8'd5}, 8'd5, 3'd1, 11, 32'h0099_00AA);
    wait_done();

    // Clamp 100 -> 64 streamed entries.
    start_run(100, {8'd9, 8'd4, 8'd4}, 8'd4, 3'd2, 78, 32'h00BB_00CC);
    wait_done();

    // Abort mid-stream.
    start_run(64, {8'd9, 8'd4, 8'd4}, 8'd4, 3'd2, 78, 32'h00DD_00EE);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy/valid/done", 64'({busy, core_bus.core_valid, done}), 64'd0);
    check("abort class_out", 64'(class_out), 64'd0);
    exp_q.delete();
    str_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Recovery run after abort.
    start_run(3, {8'd2, 8'd5, 8'd2}, 8'd2, 3'd2, 17, 32'h1234_5678);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
